gpio_ctrl: RTL and testbench

Parametrised APB GPIO controller, successor to the 8-pin GPIO block. Adds up to 32 pins, input synchroniser, per-pin debounce, atomic set/clear/toggle of outputs, five interrupt trigger modes with sticky write-1-to-clear status, and a combined interrupt line. Sits on the peripheral APB bus as a zero-wait-state slave; pins go to the pad ring, interrupts to the interrupt controller.

---
 rtl/gpio_ctrl_if.sv | 24 ++
 rtl/gpio_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_gpio_ctrl.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_ctrl_if.sv
// APB bus bundle for the GPIO controller. The clock and reset travel with
// the bus so that the slave sees them through the same modport.
interface apb_bus_t (
    input logic PCLK,
    input logic PRESETn
);
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;

    modport master (
        input  PCLK, PRESETn, PRDATA, PREADY,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        input  PCLK, PRESETn, PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY
    );
endinterface

// File: rtl/gpio_ctrl.sv
// Parametrised APB GPIO controller: direction/output registers with atomic
// set/clear/toggle, synchronised and optionally debounced inputs, per-pin
// edge/level interrupts with sticky write-1-to-clear status.
module gpio_ctrl #(
    parameter int N_GPIOS     = 32,
    parameter int SYNC_STAGES = 2,
    parameter int DB_W        = 16
) (
    apb_bus_t.slave              apb_bus,
    output logic [N_GPIOS-1:0]   dir_o,
    output logic [N_GPIOS-1:0]   val_o,
    input  logic [N_GPIOS-1:0]   val_i,
    output logic [N_GPIOS-1:0]   irq_o,
    output logic                 irq_any_o
);

    localparam logic [3:0] REG_DIR      = 4'd0;
    localparam logic [3:0] REG_OUT      = 4'd1;
    localparam logic [3:0] REG_IN       = 4'd2;
    localparam logic [3:0] REG_INV      = 4'd3;
    localparam logic [3:0] REG_IRQ_EN   = 4'd4;
    localparam logic [3:0] REG_IRQ_LVL  = 4'd5;
    localparam logic [3:0] REG_IRQ_POL  = 4'd6;
    localparam logic [3:0] REG_IRQ_ANY  = 4'd7;
    localparam logic [3:0] REG_STATUS   = 4'd8;
    localparam logic [3:0] REG_DB_EN    = 4'd9;
    localparam logic [3:0] REG_DB_CNT   = 4'd10;
    localparam logic [3:0] REG_OUT_SET  = 4'd11;
    localparam logic [3:0] REG_OUT_CLR  = 4'd12;
    localparam logic [3:0] REG_OUT_TGL  = 4'd13;

    logic                clk;
    logic                rst_n;
    logic                access;
    logic                wr_en;
    logic                rd_en;
    logic [3:0]          reg_idx;
    logic [N_GPIOS-1:0]  wdata;
    logic [31:0]         rdata;
    logic                unused_bits;

    logic [N_GPIOS-1:0]  dir_q;
    logic [N_GPIOS-1:0]  out_q;
    logic [N_GPIOS-1:0]  inv_q;
    logic [N_GPIOS-1:0]  irq_en_q;
    logic [N_GPIOS-1:0]  irq_lvl_q;
    logic [N_GPIOS-1:0]  irq_pol_q;
    logic [N_GPIOS-1:0]  irq_any_q;
    logic [N_GPIOS-1:0]  status_q;
    logic [N_GPIOS-1:0]  db_en_q;
    logic [DB_W-1:0]     db_cnt_q;

    logic [N_GPIOS-1:0]  sync_q [SYNC_STAGES];
    logic [N_GPIOS-1:0]  sync_in;
    logic [N_GPIOS-1:0]  filt_q;
    logic [DB_W-1:0]     cnt_q [N_GPIOS];
    logic [N_GPIOS-1:0]  in_val;
    logic [N_GPIOS-1:0]  prev_q;

    logic [N_GPIOS-1:0]  rise;
    logic [N_GPIOS-1:0]  fall;
    logic [N_GPIOS-1:0]  edge_evt;
    logic [N_GPIOS-1:0]  lvl_evt;
    logic [N_GPIOS-1:0]  w1c;

    assign clk     = apb_bus.PCLK;
    assign rst_n   = apb_bus.PRESETn;
    assign access  = apb_bus.PSEL & apb_bus.PENABLE;
    assign wr_en   = access & apb_bus.PWRITE;
    assign rd_en   = access & ~apb_bus.PWRITE;
    assign reg_idx = apb_bus.PADDR[5:2];
    assign wdata   = apb_bus.PWDATA[N_GPIOS-1:0];

    // Address bits outside the register index are not decoded
    assign unused_bits = ^{apb_bus.PADDR[31:6], apb_bus.PADDR[1:0], apb_bus.PWDATA};

    // Zero-wait-state slave: every access phase completes immediately
    assign apb_bus.PREADY = access;
    assign apb_bus.PRDATA = rd_en ? rdata : 32'd0;

    // Control register writes, including atomic OUT set/clear/toggle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q     <= '0;
            out_q     <= '0;
            inv_q     <= '0;
            irq_en_q  <= '0;
            irq_lvl_q <= '0;
            irq_pol_q <= '0;
            irq_any_q <= '0;
            db_en_q   <= '0;
            db_cnt_q  <= '0;
        end else if (wr_en) begin
            case (reg_idx)
                REG_DIR:     dir_q     <= wdata;
                REG_OUT:     out_q     <= wdata;
                REG_INV:     inv_q     <= wdata;
                REG_IRQ_EN:  irq_en_q  <= wdata;
                REG_IRQ_LVL: irq_lvl_q <= wdata;
                REG_IRQ_POL: irq_pol_q <= wdata;
                REG_IRQ_ANY: irq_any_q <= wdata;
                REG_DB_EN:   db_en_q   <= wdata;
                REG_DB_CNT:  db_cnt_q  <= apb_bus.PWDATA[DB_W-1:0];
                REG_OUT_SET: out_q     <= out_q | wdata;
                REG_OUT_CLR: out_q     <= out_q & ~wdata;
                REG_OUT_TGL: out_q     <= out_q ^ wdata;
                default:     ;
            endcase
        end
    end

    // Pad input synchroniser chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= val_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync_in = sync_q[SYNC_STAGES-1];

    // Per-pin debounce: a change must persist for DB_CNT+1 cycles to reach filt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= '0;
            for (int i = 0; i < N_GPIOS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_GPIOS; i++) begin
                if (!db_en_q[i]) begin
                    filt_q[i] <= sync_in[i];
                    cnt_q[i]  <= '0;
                end else if (sync_in[i] == filt_q[i]) begin
                    cnt_q[i]  <= '0;
                end else if (cnt_q[i] == db_cnt_q) begin
                    filt_q[i] <= sync_in[i];
                    cnt_q[i]  <= '0;
                end else begin
                    cnt_q[i]  <= cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    assign in_val = filt_q ^ inv_q;

    // Previous IN value for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
        end else begin
            prev_q <= in_val;
        end
    end

    assign rise     = in_val & ~prev_q;
    assign fall     = ~in_val & prev_q;
    assign edge_evt = ~dir_q & ~irq_lvl_q &
                      ((irq_any_q & (rise | fall)) |
                       (~irq_any_q & ~irq_pol_q & rise) |
                       (~irq_any_q &  irq_pol_q & fall));
    assign lvl_evt  = ~dir_q & irq_lvl_q & (in_val ^ irq_pol_q);
    assign w1c      = (wr_en && reg_idx == REG_STATUS) ? wdata : '0;

    // Sticky status: an edge beats a same-cycle clear; a held level is
    // cleared for one cycle by W1C and re-asserts on the following cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q <= '0;
        end else begin
            status_q <= (status_q & ~w1c) | edge_evt | (lvl_evt & ~w1c);
        end
    end

    // Register read mux; write-only and unmapped indices read zero
    always_comb begin
        rdata = 32'd0;
        case (reg_idx)
            REG_DIR:     rdata = 32'(dir_q);
            REG_OUT:     rdata = 32'(out_q);
            REG_IN:      rdata = 32'(in_val);
            REG_INV:     rdata = 32'(inv_q);
            REG_IRQ_EN:  rdata = 32'(irq_en_q);
            REG_IRQ_LVL: rdata = 32'(irq_lvl_q);
            REG_IRQ_POL: rdata = 32'(irq_pol_q);
            REG_IRQ_ANY: rdata = 32'(irq_any_q);
            REG_STATUS:  rdata = 32'(status_q);
            REG_DB_EN:   rdata = 32'(db_en_q);
            REG_DB_CNT:  rdata = 32'(db_cnt_q);
            default:     rdata = 32'd0;
        endcase
    end

    assign dir_o     = dir_q;
    assign val_o     = dir_q & (out_q ^ inv_q);
    assign irq_o     = status_q & irq_en_q;
    assign irq_any_o = |irq_o;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed self-checking bench for gpio_ctrl with hand-computed expectations.
module tb_gpio_ctrl;

    localparam logic [3:0] DIR = 4'd0, OUT = 4'd1, IN = 4'd2, INV = 4'd3;
    localparam logic [3:0] IRQ_EN = 4'd4, IRQ_LVL = 4'd5, IRQ_POL = 4'd6, IRQ_ANY = 4'd7;
    localparam logic [3:0] STATUS = 4'd8, DB_EN = 4'd9, DB_CNT = 4'd10;
    localparam logic [3:0] OUT_SET = 4'd11, OUT_CLR = 4'd12, OUT_TGL = 4'd13;

    logic        clk;
    logic        rst_n;
    logic [31:0] val_i;
    logic [31:0] dir_o;
    logic [31:0] val_o;
    logic [31:0] irq_o;
    logic        irq_any_o;
    logic [31:0] rd;
    int          check_count;
    int          pass_count;

    apb_bus_t bus (.PCLK(clk), .PRESETn(rst_n));

    gpio_ctrl #(.N_GPIOS(32), .SYNC_STAGES(2), .DB_W(16)) dut (
        .apb_bus   (bus),
        .dir_o     (dir_o),
        .val_o     (val_o),
        .val_i     (val_i),
        .irq_o     (irq_o),
        .irq_any_o (irq_any_o)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expectation and count it
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end else begin
            pass_count++;
        end
    endtask

    // Drive one pad input bit
    task automatic applyStimulus(input int pin, input logic value);
        val_i[pin] = value;
    endtask

    // Advance n cycles and settle just after the edge
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // APB write: setup, access, commit on the third edge
    task automatic bus_write(input logic [3:0] idx, input logic [31:0] data);
        @(posedge clk); #1;
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b1;
        bus.PADDR   = {26'd0, idx, 2'b00};
        bus.PWDATA  = data;
        @(posedge clk); #1;
        bus.PENABLE = 1'b1;
        @(posedge clk); #1;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
    endtask

    // APB read: data sampled in the access phase
    task automatic bus_read(input logic [3:0] idx, output logic [31:0] data);
        @(posedge clk); #1;
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
        bus.PADDR   = {26'd0, idx, 2'b00};
        @(posedge clk); #1;
        bus.PENABLE = 1'b1;
        #1;
        data = bus.PRDATA;
        checkOutput("pready", {31'd0, bus.PREADY}, 32'd1);
        @(posedge clk); #1;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
    endtask

    // Hang guard
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] timeout");
    end

    // Directed scenario sequence
    initial begin
        check_count = 0;
        pass_count  = 0;
        rst_n       = 1'b0;
        val_i       = 32'd0;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
        bus.PADDR   = 32'd0;
        bus.PWDATA  = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] reset state and output register");
        checkOutput("rst_val_o", val_o, 32'd0);
        checkOutput("rst_dir_o", dir_o, 32'd0);
        checkOutput("rst_irq_any", {31'd0, irq_any_o}, 32'd0);
        checkOutput("rst_prdata", bus.PRDATA, 32'd0);
        for (int i = 0; i < 16; i++) begin
            bus_read(4'(i), rd);
            checkOutput($sformatf("rst_reg%0d", i), rd, 32'd0);
        end
        bus_write(DIR, 32'hFF);
        bus_write(OUT, 32'hA5);
        checkOutput("val_o_a5", val_o, 32'hA5);
        checkOutput("dir_o_ff", dir_o, 32'hFF);
        bus_write(OUT_SET, 32'h0F0);
        bus_read(OUT, rd);
        checkOutput("out_set", rd, 32'hF5);
        bus_write(OUT_CLR, 32'h5);
        bus_read(OUT, rd);
        checkOutput("out_clr", rd, 32'hF0);
        bus_write(OUT_TGL, 32'hFF);
        bus_read(OUT, rd);
        checkOutput("out_tgl", rd, 32'h0F);
        checkOutput("val_o_0f", val_o, 32'h0F);
        bus_write(DIR, 32'h0);
        checkOutput("val_o_dir0", val_o, 32'd0);

        $display("[TB] rising edge interrupt latency");
        bus_write(IRQ_EN, 32'h8);
        applyStimulus(3, 1'b1);
        wait_cycles(3);
        checkOutput("rise_early", irq_o, 32'd0);
        wait_cycles(1);
        checkOutput("rise_irq", irq_o, 32'h8);
        checkOutput("rise_any", {31'd0, irq_any_o}, 32'd1);
        bus_write(STATUS, 32'h8);
        checkOutput("rise_w1c", irq_o, 32'd0);
        applyStimulus(3, 1'b0);
        wait_cycles(6);
        checkOutput("fall_no_irq", irq_o, 32'd0);
        bus_read(STATUS, rd);
        checkOutput("fall_no_status", rd, 32'd0);

        $display("[TB] trigger modes");
        bus_write(IRQ_ANY, 32'h2);
        bus_write(IRQ_EN, 32'h2);
        applyStimulus(1, 1'b1);
        wait_cycles(5);
        checkOutput("any_rise", irq_o, 32'h2);
        bus_write(STATUS, 32'h2);
        checkOutput("any_w1c", irq_o, 32'd0);
        applyStimulus(1, 1'b0);
        wait_cycles(5);
        checkOutput("any_fall", irq_o, 32'h2);
        bus_write(STATUS, 32'h2);

        bus_write(IRQ_POL, 32'h4);
        bus_write(IRQ_EN, 32'h4);
        applyStimulus(2, 1'b1);
        wait_cycles(5);
        checkOutput("pol_rise_none", irq_o, 32'd0);
        applyStimulus(2, 1'b0);
        wait_cycles(5);
        checkOutput("pol_fall", irq_o, 32'h4);
        bus_write(STATUS, 32'h4);

        bus_write(IRQ_POL, 32'h0);
        bus_write(IRQ_LVL, 32'h10);
        bus_write(IRQ_EN, 32'h10);
        applyStimulus(4, 1'b1);
        wait_cycles(5);
        checkOutput("lvl_high", irq_o, 32'h10);
        bus_write(STATUS, 32'h10);
        checkOutput("lvl_cleared", irq_o, 32'd0);
        wait_cycles(1);
        checkOutput("lvl_reset", irq_o, 32'h10);
        applyStimulus(4, 1'b0);
        wait_cycles(5);
        bus_write(STATUS, 32'h10);
        wait_cycles(1);
        checkOutput("lvl_low", irq_o, 32'd0);
        bus_write(IRQ_LVL, 32'h0);
        bus_write(IRQ_ANY, 32'h0);

        $display("[TB] debounce");
        bus_write(STATUS, 32'hFFFF_FFFF);
        bus_write(DB_CNT, 32'd10);
        bus_write(DB_EN, 32'h1);
        bus_write(IRQ_EN, 32'h1);
        applyStimulus(0, 1'b1);
        repeat (10) @(posedge clk);
        #1 applyStimulus(0, 1'b0);
        wait_cycles(20);
        checkOutput("db_short_irq", irq_o, 32'd0);
        bus_read(IN, rd);
        checkOutput("db_short_in", rd, 32'd0);
        applyStimulus(0, 1'b1);
        repeat (11) @(posedge clk);
        #1 applyStimulus(0, 1'b0);
        wait_cycles(2);
        checkOutput("db_before", irq_o, 32'd0);
        wait_cycles(1);
        checkOutput("db_after", irq_o, 32'h1);
        bus_read(IN, rd);
        checkOutput("db_in", rd, 32'h1);
        bus_read(DB_CNT, rd);
        checkOutput("db_cnt_rd", rd, 32'd10);
        wait_cycles(30);
        bus_write(DB_EN, 32'h0);
        bus_write(IRQ_EN, 32'h0);
        bus_write(STATUS, 32'hFFFF_FFFF);

        $display("[TB] inversion and output pins");
        bus_write(INV, 32'h20);
        bus_read(IN, rd);
        checkOutput("inv_in", rd, 32'h20);
        bus_write(INV, 32'h0);
        bus_write(STATUS, 32'hFFFF_FFFF);
        bus_write(DIR, 32'h40);
        bus_write(IRQ_EN, 32'h40);
        applyStimulus(6, 1'b1);
        wait_cycles(5);
        bus_read(IN, rd);
        checkOutput("loop_in_hi", rd, 32'h40);
        checkOutput("out_pin_irq", irq_o, 32'd0);
        applyStimulus(6, 1'b0);
        wait_cycles(5);
        bus_read(IN, rd);
        checkOutput("loop_in_lo", rd, 32'd0);
        bus_read(STATUS, rd);
        checkOutput("out_pin_status", rd, 32'd0);
        bus_write(DIR, 32'h0);

        $display("[TB] collisions");
        bus_write(IRQ_ANY, 32'h80);
        bus_write(IRQ_EN, 32'h80);
        applyStimulus(7, 1'b1);
        wait_cycles(5);
        checkOutput("col_first", irq_o, 32'h80);
        applyStimulus(7, 1'b0);
        @(posedge clk);
        bus_write(STATUS, 32'h80);
        checkOutput("col_set_wins", irq_o, 32'h80);
        bus_write(STATUS, 32'h80);
        checkOutput("col_cleared", irq_o, 32'd0);
        bus_read(4'd14, rd);
        checkOutput("rd_idx14", rd, 32'd0);
        bus_read(OUT_SET, rd);
        checkOutput("rd_out_set", rd, 32'd0);

        $display("[TB] reset mid-operation");
        bus_write(IRQ_ANY, 32'h0);
        bus_write(DIR, 32'hF0);
        bus_write(OUT, 32'h30);
        checkOutput("pre_rst_val_o", val_o, 32'h30);
        bus_write(IRQ_EN, 32'h8);
        applyStimulus(3, 1'b1);
        wait_cycles(5);
        checkOutput("pre_rst_irq", {31'd0, irq_any_o}, 32'd1);
        bus_write(DB_EN, 32'h1);
        applyStimulus(0, 1'b1);
        wait_cycles(5);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_val_o", val_o, 32'd0);
        checkOutput("mid_rst_dir_o", dir_o, 32'd0);
        checkOutput("mid_rst_irq", irq_o, 32'd0);
        checkOutput("mid_rst_any", {31'd0, irq_any_o}, 32'd0);
        val_i = 32'd0;
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(10);
        bus_read(STATUS, rd);
        checkOutput("post_rst_status", rd, 32'd0);
        bus_read(DIR, rd);
        checkOutput("post_rst_dir", rd, 32'd0);
        bus_read(DB_CNT, rd);
        checkOutput("post_rst_dbcnt", rd, 32'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
